// File: rtl/spike_pkg.sv
// Shared spike-domain definitions: bank geometry, AER word layout, scan FSM encoding.
// Used by the LIF bank, the AER encoder and downstream AER consumers.
package spike_pkg;

  localparam int N_NEURONS  = 8;
  localparam int ADDR_W     = $clog2(N_NEURONS);
  localparam int TS_W       = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int AER_W      = TS_W + ADDR_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] addr;
  } aer_word_t;

  function automatic logic [ADDR_W-1:0] lowest_set(input logic [N_NEURONS-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) idx = ADDR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous first-word-visible FIFO with occupancy; pushes are refused when full
// even if a pop happens in the same cycle.
module spike_event_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             push_ok, pop_ok;

  assign full    = (level_q == (PTR_W+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises per-timestep spike vectors into {ts, addr} AER events, lowest address first.
// SPIKE_AER_DROP_ON_FULL_EN: drop events when the FIFO is full and set sticky overflow.
//
// state   | meaning
// IDLE    | waiting for a spike vector; spike_ready high
// SCAN    | emitting one event per cycle from the latched mask
module spike_aer_encoder
  import spike_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_NEURONS-1:0]            spike_in,
  input  logic                            spike_valid,
  output logic                            spike_ready,
  output logic [ADDR_W-1:0]               aer_addr,
  output logic [TS_W-1:0]                 aer_ts,
  output logic                            aer_valid,
  input  logic                            aer_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);

  scan_state_e          state_q;
  logic [N_NEURONS-1:0] mask_q;
  logic [N_NEURONS-1:0] mask_clr;
  logic [TS_W-1:0]      ts_cnt_q, ts_lat_q;
  logic                 spike_ready_q;
  logic                 full, empty, push, pop, advance;
  aer_word_t            push_word, head_word;
  logic [AER_W-1:0]     head_raw;

  assign mask_clr  = mask_q & (mask_q - 1'b1);
  assign push_word = '{ts: ts_lat_q, addr: lowest_set(mask_q)};
  assign push      = (state_q == ST_SCAN) && !full;
  assign pop       = aer_valid && aer_ready;

`ifdef SPIKE_AER_DROP_ON_FULL_EN
  logic overflow_q;
  assign advance  = (state_q == ST_SCAN);
  assign overflow = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                overflow_q <= 1'b0;
    else if ((state_q == ST_SCAN) && full)     overflow_q <= 1'b1;
  end
`else
  assign advance  = push;
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      ts_cnt_q      <= '0;
      ts_lat_q      <= '0;
      spike_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (spike_valid) begin
            ts_lat_q <= ts_cnt_q;
            ts_cnt_q <= ts_cnt_q + 1'b1;
            if (spike_in != '0) begin
              mask_q        <= spike_in;
              state_q       <= ST_SCAN;
              spike_ready_q <= 1'b0;
            end
          end
        end
        ST_SCAN: begin
          if (advance) begin
            mask_q <= mask_clr;
            if (mask_clr == '0) begin
              state_q       <= ST_IDLE;
              spike_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          spike_ready_q <= 1'b1;
        end
      endcase
    end
  end

  spike_event_fifo #(
    .WIDTH(AER_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(push_word),
    .pop  (pop),
    .rdata(head_raw),
    .full (full),
    .empty(empty),
    .level(fifo_level)
  );

  // Head is gated so the pins read zero whenever nothing is queued, including right after reset.
  assign head_word   = empty ? '0 : aer_word_t'(head_raw);
  assign aer_valid   = !empty;
  assign aer_addr    = head_word.addr;
  assign aer_ts      = head_word.ts;
  assign spike_ready = spike_ready_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder: stimulus pushes expected AER words,
// a negedge monitor pops and compares on every handshake.
module tb_spike_aer_encoder;

`ifdef SPIKE_AER_DROP_ON_FULL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] spike_in = '0;
  logic       spike_valid = 1'b0;
  logic       spike_ready;
  logic [2:0] aer_addr;
  logic [7:0] aer_ts;
  logic       aer_valid;
  logic       aer_ready = 1'b0;
  logic [3:0] fifo_level;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  tb_ts = '0;

  always #5 clk = ~clk;

  spike_aer_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .spike_valid(spike_valid),
    .spike_ready(spike_ready),
    .aer_addr   (aer_addr),
    .aer_ts     (aer_ts),
    .aer_valid  (aer_valid),
    .aer_ready  (aer_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && aer_valid && aer_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL event_extra: got ts=%0d addr=%0d expected none", aer_ts, aer_addr);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({aer_ts, aer_addr} !== e) begin
          failures++;
          $display("FAIL event: got ts=%0d addr=%0d expected ts=%0d addr=%0d",
                   aer_ts, aer_addr, e[10:3], e[2:0]);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    spike_valid = 1'b0;
    spike_in = '0;
    exp_q.delete();
    tb_ts = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [7:0] v, input bit expect_ev);
    int t;
    t = 0;
    while (!spike_ready && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    if (!spike_ready) begin
      chk("spike_ready_wait", {31'd0, spike_ready}, 32'd1);
      return;
    end
    spike_in = v;
    spike_valid = 1'b1;
    if (expect_ev)
      for (int i = 0; i < 8; i++)
        if (v[i]) exp_q.push_back({tb_ts, 3'(i)});
    tb_ts = tb_ts + 8'd1;
    @(posedge clk);
    #1;
    spike_valid = 1'b0;
    spike_in = '0;
  endtask

  task automatic drain(input string name);
    aer_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !aer_valid) break;
    end
    chk({name, "_left"}, exp_q.size(), 32'd0);
    chk({name, "_valid"}, {31'd0, aer_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;

    // reset values
    do_reset();
    @(negedge clk);
    chk("rst_spike_ready", {31'd0, spike_ready}, 32'd1);
    chk("rst_aer_valid", {31'd0, aer_valid}, 32'd0);
    chk("rst_fifo_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;

    // 1010_0101 -> a0,a2,a5,a7 at ts0; spike_ready low 4 cycles
    aer_ready = 1'b1;
    send_vec(8'hA5, 1'b1);
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (spike_ready) break;
      cnt++;
    end
    chk("t1_busy_cycles", cnt, 32'd4);
    drain("t1_drain");

    // zero vector keeps ts moving without events
    do_reset();
    aer_ready = 1'b1;
    send_vec(8'h00, 1'b1);
    @(negedge clk);
    chk("t2_ready_after_zero", {31'd0, spike_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_vec(8'h01, 1'b1);
    send_vec(8'h80, 1'b1);
    drain("t2_drain");

    // backpressure: FF fills the FIFO, 03 stalls (or drops)
    do_reset();
    aer_ready = 1'b0;
    send_vec(8'hFF, 1'b1);
    send_vec(8'h03, !DROP);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t3_level_full", {28'd0, fifo_level}, 32'd8);
    chk("t3_spike_ready", {31'd0, spike_ready}, DROP ? 32'd1 : 32'd0);
    chk("t3_overflow", {31'd0, overflow}, DROP ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    drain("t3_drain");
    chk("t3_overflow_sticky", {31'd0, overflow}, DROP ? 32'd1 : 32'd0);

    // timestep wrap after 256 zero vectors
    do_reset();
    aer_ready = 1'b1;
    for (int i = 0; i < 256; i++) send_vec(8'h00, 1'b1);
    chk("t4_model_ts_wrapped", {24'd0, tb_ts}, 32'd0);
    send_vec(8'h10, 1'b1);
    drain("t4_drain");

    // reset mid-scan of F0 after two pushes
    do_reset();
    aer_ready = 1'b0;
    send_vec(8'hF0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t5_level_before", {28'd0, fifo_level}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", {31'd0, spike_ready}, 32'd1);
    chk("t5_rst_valid", {31'd0, aer_valid}, 32'd0);
    chk("t5_rst_addr", {29'd0, aer_addr}, 32'd0);
    chk("t5_rst_ts", {24'd0, aer_ts}, 32'd0);
    chk("t5_rst_level", {28'd0, fifo_level}, 32'd0);
    chk("t5_rst_overflow", {31'd0, overflow}, 32'd0);
    do_reset();
    chk("t5_level_after", {28'd0, fifo_level}, 32'd0);
    aer_ready = 1'b1;
    send_vec(8'h01, 1'b1);
    drain("t5_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
